// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA raster constants and the per-axis phase encoding.
// Consumed by vga_sync_gen and vga_tick_div.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-tick divider: a one-clock p_tick every CLK_DIV system clocks.
// p_tick is registered and is high exactly while the divider count equals CLK_DIV-1.
module vga_tick_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);
  localparam logic [W-1:0] DIV_PRE  = W'(CLK_DIV - 2);

  logic [W-1:0] div_cnt_q, div_cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    // Pre-decoding one count early lets the pulse come straight from a flop.
    tick_d    = (div_cnt_q == DIV_PRE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign p_tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel tick, x/y scan counters, hsync/vsync/video_on and frame_start.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/video_on by one pixel tick.
module vga_sync_gen
  import vga_timing_pkg::phase_e, vga_timing_pkg::PH_ACTIVE, vga_timing_pkg::PH_FRONT,
         vga_timing_pkg::PH_SYNC, vga_timing_pkg::PH_BACK, vga_timing_pkg::CNT_W;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_FRONT_AT = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] H_SYNC_AT  = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] H_BACK_AT  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_FRONT_AT = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] V_SYNC_AT  = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] V_BACK_AT  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit a 10-bit counter");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be at least 2");
  end

  logic tick;

  vga_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .p_tick(tick)
  );

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Axis 0 is horizontal (steps every tick), axis 1 vertical (steps on line wrap).
  logic [1:0]            adv;
  logic [1:0][CNT_W-1:0] pos_d;
  logic [1:0]            active_d;
  logic [1:0]            sync_d;

  assign adv   = {tick & (x_q == H_LAST), tick};
  assign pos_d = {y_d, x_d};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic [CNT_W-1:0] FRONT_AT = (gi == 0) ? H_FRONT_AT : V_FRONT_AT;
    localparam logic [CNT_W-1:0] SYNC_AT  = (gi == 0) ? H_SYNC_AT  : V_SYNC_AT;
    localparam logic [CNT_W-1:0] BACK_AT  = (gi == 0) ? H_BACK_AT  : V_BACK_AT;

    phase_e ph_q, ph_d;

    // Decoded from the next counter value so the phase flips on the same edge as x/y.
    always_comb begin
      ph_d = ph_q;
      if (adv[gi]) begin
        case (ph_q)
          PH_ACTIVE: if (pos_d[gi] == FRONT_AT) ph_d = PH_FRONT;
          PH_FRONT:  if (pos_d[gi] == SYNC_AT)  ph_d = PH_SYNC;
          PH_SYNC:   if (pos_d[gi] == BACK_AT)  ph_d = PH_BACK;
          PH_BACK:   if (pos_d[gi] == '0)       ph_d = PH_ACTIVE;
          default:   ph_d = PH_ACTIVE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        ph_q <= PH_ACTIVE;
      end else begin
        ph_q <= ph_d;
      end
    end

    assign active_d[gi] = (ph_d == PH_ACTIVE);
    assign sync_d[gi]   = (ph_d == PH_SYNC);
  end

  logic hsync_q, vsync_q, video_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= ~sync_d[0];
      vsync_q <= ~sync_d[1];
      video_q <= &active_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_dly_q, vsync_dly_q, video_dly_q;

  // Lags the raster by one pixel to line up with a registered rgb path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync_dly_q <= 1'b1;
      vsync_dly_q <= 1'b1;
      video_dly_q <= 1'b0;
    end else if (tick) begin
      hsync_dly_q <= hsync_q;
      vsync_dly_q <= vsync_q;
      video_dly_q <= video_q;
    end
  end

  assign hsync    = hsync_dly_q;
  assign vsync    = vsync_dly_q;
  assign video_on = video_dly_q;
`else
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_q;
`endif

  assign p_tick      = tick;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = tick & (x_q == H_LAST) & (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a raster model pushes expected outputs per clock,
// the scenario tasks pop and compare them. Uses a short frame (8 lines) to keep runs small.
module tb_vga_sync_gen;

  localparam int CD = 4;
  localparam int HD = 640, HF = 16, HS = 96, HB = 48;
  localparam int HT = HD + HF + HS + HB;
  localparam int VD = 4, VF = 1, VS = 2, VB = 1;
  localparam int VT = VD + VF + VS + VB;
  localparam int HS_START = HD + HF;
  localparam int HS_END   = HS_START + HS - 1;
  localparam int VS_START = VD + VF;
  localparam int VS_END   = VS_START + VS - 1;
  localparam int FRAME_CLKS = HT * VT * CD;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       p_tick;
  logic [9:0] x, y;
  logic       video_on, hsync, vsync, frame_start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  typedef struct {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
  } exp_t;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint clk_count = 0;

  int   m_div = 0, m_x = 0, m_y = 0;
  logic m_dh = 1'b1, m_dv = 1'b1, m_dvid = 1'b0;

  function automatic exp_t raster(int div, int xx, int yy);
    exp_t r;
    r.p_tick      = (div == CD - 1);
    r.x           = 10'(xx);
    r.y           = 10'(yy);
    r.video_on    = (xx < HD) && (yy < VD);
    r.hsync       = !((xx >= HS_START) && (xx <= HS_END));
    r.vsync       = !((yy >= VS_START) && (yy <= VS_END));
    r.frame_start = r.p_tick && (xx == HT - 1) && (yy == VT - 1);
    return r;
  endfunction

  task automatic model_step();
    exp_t cur, e;
    cur = raster(m_div, m_x, m_y);
    if (!reset) begin
      m_div = 0; m_x = 0; m_y = 0;
      m_dh = 1'b1; m_dv = 1'b1; m_dvid = 1'b0;
    end else begin
      if (m_div == CD - 1) begin
        m_dh = cur.hsync; m_dv = cur.vsync; m_dvid = cur.video_on;
        if (m_x == HT - 1) begin
          m_x = 0;
          m_y = (m_y == VT - 1) ? 0 : m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
      end
      m_div = (m_div == CD - 1) ? 0 : m_div + 1;
    end
    e = raster(m_div, m_x, m_y);
    if (DLY) begin
      e.hsync = m_dh; e.vsync = m_dv; e.video_on = m_dvid;
    end
    sb_q.push_back(e);
    clk_count++;
  endtask

  // Advance one clock: expectation is queued at the edge, popped once outputs settle.
  task automatic next_cycle(output exp_t e);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: no expected entry at clock %0d", clk_count);
      e = raster(0, 0, 0);
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle(e);
      n_checks++;
      if ({x, y, hsync, vsync, video_on, p_tick, frame_start} !==
          {e.x, e.y, e.hsync, e.vsync, e.video_on, e.p_tick, e.frame_start}) begin
        n_fail++;
        $display("FAIL reset_state: got x=%0d y=%0d hs=%b vs=%b vid=%b tick=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b vid=%b tick=0 fs=0",
                 x, y, hsync, vsync, video_on, p_tick, frame_start, e.x, e.y, e.hsync, e.vsync, e.video_on);
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= CD; i++) begin
      next_cycle(e);
      n_checks++;
      if (p_tick !== e.p_tick || x !== e.x) begin
        n_fail++;
        $display("FAIL first_tick clk%0d: got tick=%b x=%0d, want tick=%b x=%0d", i, p_tick, x, e.p_tick, e.x);
      end
      if (i == CD - 1) begin
        n_checks++;
        if (p_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL first_tick_pos: got tick=%b, want 1", p_tick);
        end
      end
    end
    n_checks++;
    if (x !== 10'd1) begin
      n_fail++;
      $display("FAIL x_after_first_tick: got %0d, want 1", x);
    end
    $display("info: test_reset done at clock %0d", clk_count);
  endtask

  task automatic test_line();
    exp_t   e;
    int     hs_low = 0, ticks = 0;
    longint last_tick = -1;
    logic [9:0] px, py;
    px = x; py = y;
    for (int i = 0; i < HT * CD; i++) begin
      next_cycle(e);
      n_checks++;
      if ({p_tick, x, y, hsync, video_on} !== {e.p_tick, e.x, e.y, e.hsync, e.video_on}) begin
        n_fail++;
        $display("FAIL line_cycle: got tick=%b x=%0d y=%0d hs=%b vid=%b, want tick=%b x=%0d y=%0d hs=%b vid=%b",
                 p_tick, x, y, hsync, video_on, e.p_tick, e.x, e.y, e.hsync, e.video_on);
      end
      if (hsync === 1'b0) hs_low++;
      if (p_tick === 1'b1) begin
        ticks++;
        if (last_tick >= 0) begin
          n_checks++;
          if (clk_count - last_tick != CD) begin
            n_fail++;
            $display("FAIL tick_period: got %0d clocks, want %0d", clk_count - last_tick, CD);
          end
        end
        last_tick = clk_count;
      end
      if (px == 10'(HT - 1) && x == 10'd0) begin
        n_checks++;
        if (y !== 10'((py + 1) % VT)) begin
          n_fail++;
          $display("FAIL line_wrap_y: got y=%0d, want %0d", y, (py + 1) % VT);
        end
      end
      px = x; py = y;
    end
    n_checks++;
    if (hs_low != HS * CD) begin
      n_fail++;
      $display("FAIL hsync_low_clocks: got %0d, want %0d", hs_low, HS * CD);
    end
    n_checks++;
    if (ticks != HT) begin
      n_fail++;
      $display("FAIL ticks_per_line: got %0d, want %0d", ticks, HT);
    end
    $display("info: test_line done, hsync low %0d clocks, %0d ticks", hs_low, ticks);
  endtask

  task automatic test_frame();
    exp_t   e;
    int     guard = 0, vs_low_ticks = 0, fs_count = 0, point_hits = 0;
    longint t0;
    do begin
      next_cycle(e);
      guard++;
    end while (frame_start !== 1'b1 && guard < 2 * FRAME_CLKS);
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_frame_start: got none in %0d clocks, want a pulse", guard);
      return;
    end
    t0 = clk_count;
    guard = 0;
    do begin
      next_cycle(e);
      guard++;
      n_checks++;
      if ({x, y, hsync, vsync, video_on, frame_start} !==
          {e.x, e.y, e.hsync, e.vsync, e.video_on, e.frame_start}) begin
        n_fail++;
        $display("FAIL frame_cycle: got x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b",
                 x, y, hsync, vsync, video_on, frame_start, e.x, e.y, e.hsync, e.vsync, e.video_on, e.frame_start);
      end
      if (p_tick === 1'b1 && vsync === 1'b0) vs_low_ticks++;
      if (frame_start === 1'b1) fs_count++;
      if (p_tick === 1'b1 && x == 10'd0 && y == 10'(VD + 1)) begin
        point_hits++;
        n_checks++;
        if (video_on !== 1'b0) begin
          n_fail++;
          $display("FAIL point_video_on: got %b, want 0", video_on);
        end
      end
    end while (frame_start !== 1'b1 && guard < 2 * FRAME_CLKS);
    n_checks++;
    if (clk_count - t0 != FRAME_CLKS) begin
      n_fail++;
      $display("FAIL frame_period: got %0d clocks, want %0d", clk_count - t0, FRAME_CLKS);
    end
    n_checks++;
    if (fs_count != 1) begin
      n_fail++;
      $display("FAIL frame_start_count: got %0d, want 1", fs_count);
    end
    n_checks++;
    if (vs_low_ticks != VS * HT) begin
      n_fail++;
      $display("FAIL vsync_low_ticks: got %0d, want %0d", vs_low_ticks, VS * HT);
    end
    n_checks++;
    if (point_hits != 1) begin
      n_fail++;
      $display("FAIL point_hits: got %0d, want 1", point_hits);
    end
    $display("info: test_frame done, period %0d clocks, vsync low %0d ticks", clk_count - t0, vs_low_ticks);
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   guard = 0;
    do begin
      next_cycle(e);
      guard++;
    end while (!(x == 10'd300 && y == 10'd2) && guard < 2 * FRAME_CLKS);
    n_checks++;
    if (!(x == 10'd300 && y == 10'd2)) begin
      n_fail++;
      $display("FAIL wait_mid_point: got x=%0d y=%0d, want x=300 y=2", x, y);
      return;
    end
    reset = 1'b0;
    next_cycle(e);
    reset = 1'b1;
    n_checks++;
    if ({x, y, p_tick} !== 21'd0 || {x, y, p_tick, video_on} !== {e.x, e.y, e.p_tick, e.video_on}) begin
      n_fail++;
      $display("FAIL mid_reset_state: got x=%0d y=%0d tick=%b vid=%b, want x=0 y=0 tick=0 vid=%b",
               x, y, p_tick, video_on, e.video_on);
    end
    for (int i = 1; i <= CD; i++) begin
      next_cycle(e);
      n_checks++;
      if (p_tick !== e.p_tick || x !== e.x) begin
        n_fail++;
        $display("FAIL mid_reset_tick clk%0d: got tick=%b x=%0d, want tick=%b x=%0d", i, p_tick, x, e.p_tick, e.x);
      end
    end
    n_checks++;
    if (x !== 10'd1 || y !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got x=%0d y=%0d, want x=1 y=0", x, y);
    end
    $display("info: test_mid_reset done at clock %0d", clk_count);
  endtask

  task automatic test_sync_alignment();
    exp_t e;
    int   want_x[4] = '{HD, HD + 1, HS_START, HS_START + 1};
    logic want_v[4];
    want_v[0] = DLY; want_v[1] = 1'b0; want_v[2] = DLY; want_v[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int guard = 0;
      do begin
        next_cycle(e);
        guard++;
      end while (x != 10'(want_x[k]) && guard < HT * CD * 2);
      n_checks++;
      if (x != 10'(want_x[k])) begin
        n_fail++;
        $display("FAIL wait_x%0d: got x=%0d, want %0d", want_x[k], x, want_x[k]);
      end else if (k < 2) begin
        n_checks++;
        if (video_on !== want_v[k]) begin
          n_fail++;
          $display("FAIL video_on_at_x%0d: got %b, want %b", want_x[k], video_on, want_v[k]);
        end
      end else begin
        n_checks++;
        if (hsync !== want_v[k]) begin
          n_fail++;
          $display("FAIL hsync_at_x%0d: got %b, want %b", want_x[k], hsync, want_v[k]);
        end
      end
    end
    $display("info: test_sync_alignment done (delay stage %0d)", DLY);
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_sync_alignment();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
